// File: rtl/rotation_step_sequencer_pkg.sv
// Shared state type, BCD digit limits and step-count helpers
// for the rotation step sequencer.
package rot_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      SETTLE,
      DONE
   } state_t;

   localparam logic [3:0] BCD_ZERO = 4'd0;
   localparam logic [3:0] BCD_NINE = 4'd9;

   localparam int MAX_STEPS_DEF = 9999;
   localparam int STEP_W = 14;

   function automatic logic [STEP_W-1:0] clamp_steps(
      input logic [STEP_W-1:0] s,
      input int mx
   );
      return (int'(s) > mx) ? STEP_W'(mx) : s;
   endfunction

endpackage

// File: rtl/rotation_step_sequencer_if.sv
// Move-command handshake between the control FSM and the sequencer.
interface rotation_step_sequencer_if;
   import rot_ctrl_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic [STEP_W-1:0] cmd_steps;
   logic              cmd_dir;

   modport master (
      output cmd_valid,
      output cmd_steps,
      output cmd_dir,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_steps,
      input  cmd_dir,
      output cmd_ready
   );

endinterface

// File: rtl/rotation_step_sequencer_bcd4.sv
// Four-digit BCD up/down counter with 9999 <-> 0000 wrap;
// carry and borrow ripple through all digits in one cycle.
module bcd4_updown_counter
   import rot_ctrl_pkg::*;
(
   input  logic        clk50,
   input  logic        sys_init_ctrl,
   input  logic        inc,
   input  logic        dec,
   output logic [15:0] q
);

   logic [15:0] q_n;
   logic        c;

   always_comb begin
      q_n = q;
      c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (inc && !dec && c) begin
            if (q[4*i +: 4] >= BCD_NINE) begin
               q_n[4*i +: 4] = BCD_ZERO;
            end else begin
               q_n[4*i +: 4] = q[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end else if (dec && !inc && c) begin
            if (q[4*i +: 4] == BCD_ZERO) begin
               q_n[4*i +: 4] = BCD_NINE;
            end else begin
               q_n[4*i +: 4] = q[4*i +: 4] - 4'd1;
               c = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk50 or posedge sys_init_ctrl) begin
      if (sys_init_ctrl) q <= '0;
      else               q <= q_n;
   end

endmodule

// File: rtl/rotation_step_sequencer.sv
// Turns one move command into a bounded, abortable train of step
// pulses and tracks the resulting angle as a BCD count.
module rotation_step_sequencer
   import rot_ctrl_pkg::*;
#(
   parameter int STEP_DIV   = 25000,
   parameter int PULSE_W    = 12500,
   parameter int SETTLE_CYC = 16,
   parameter int MAX_STEPS  = MAX_STEPS_DEF
) (
   input  logic                      clk50,
   input  logic                      sys_init_ctrl,
   rotation_step_sequencer_if.slave  cmd,
   input  logic                      abort,
   output logic                      rot_clk,
   output logic                      rot_en,
   output logic                      rot_dir,
   output logic                      busy,
   output logic                      done,
   output logic                      done_aborted,
   output logic [STEP_W-1:0]         steps_left,
   output logic [15:0]               angle_bcd
);

   localparam int CMAX = (STEP_DIV > SETTLE_CYC) ? STEP_DIV : SETTLE_CYC;
   localparam int CW = $clog2(CMAX + 1);

   state_t            state, state_n;
   logic [CW-1:0]     cnt, cnt_n;
   logic [STEP_W-1:0] left, left_n;
   logic [STEP_W-1:0] clamped;
   logic              dir, dir_n;
   logic              abt, abt_n;
   logic              hi, fall, step;

   assign clamped = clamp_steps(cmd.cmd_steps, MAX_STEPS);
   assign hi = (state == RUN) && (cnt < CW'(PULSE_W));
   assign fall = (state == RUN) && (cnt == CW'(PULSE_W));
   // An abort while high forces the falling edge early; it still counts.
   assign step = fall || (hi && abort);

   always_ff @(posedge clk50 or posedge sys_init_ctrl) begin
      if (sys_init_ctrl) begin
         state <= IDLE;
         cnt   <= '0;
         left  <= '0;
         dir   <= 1'b0;
         abt   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         left  <= left_n;
         dir   <= dir_n;
         abt   <= abt_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      left_n  = left;
      dir_n   = dir;
      abt_n   = abt;
      unique case (state)
         IDLE: begin
            if (cmd.cmd_valid) begin
               dir_n   = cmd.cmd_dir;
               left_n  = clamped;
               cnt_n   = '0;
               abt_n   = 1'b0;
               state_n = (clamped == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            cnt_n = (cnt == CW'(STEP_DIV - 1)) ? '0 : cnt + 1'b1;
            if (step) left_n = left - 1'b1;
            if (fall && left == STEP_W'(1)) begin
               state_n = SETTLE;
               cnt_n   = '0;
            end else if (abort) begin
               state_n = SETTLE;
               cnt_n   = '0;
               abt_n   = 1'b1;
            end
         end
         SETTLE: begin
            if (cnt == CW'(SETTLE_CYC - 1)) state_n = DONE;
            else cnt_n = cnt + 1'b1;
         end
         DONE: begin
            state_n = IDLE;
         end
      endcase
   end

   assign cmd.cmd_ready = (state == IDLE);
   assign busy          = (state != IDLE);
   assign rot_en        = (state == RUN) || (state == SETTLE);
   assign rot_clk       = hi;
   assign rot_dir       = dir;
   assign done          = (state == DONE);
   assign done_aborted  = (state == DONE) && abt;
   assign steps_left    = left;

   bcd4_updown_counter u_angle (
      .clk50         (clk50),
      .sys_init_ctrl (sys_init_ctrl),
      .inc           (step && !dir),
      .dec           (step && dir),
      .q             (angle_bcd)
   );

endmodule

// File: tb/tb_rotation_step_sequencer.sv
// Directed bench for the rotation step sequencer, STEP_DIV=10, PULSE_W=4.
module tb_rotation_step_sequencer;

   localparam int SD = 10;
   localparam int PW = 4;
   localparam int SC = 6;

   logic        clk50 = 1'b0;
   logic        sys_init_ctrl;
   logic        abort;
   logic        rot_clk, rot_en, rot_dir, busy, done, done_aborted;
   logic [13:0] steps_left;
   logic [15:0] angle_bcd;

   rotation_step_sequencer_if cmd_if ();

   rotation_step_sequencer #(
      .STEP_DIV   (SD),
      .PULSE_W    (PW),
      .SETTLE_CYC (SC),
      .MAX_STEPS  (9999)
   ) dut (
      .clk50         (clk50),
      .sys_init_ctrl (sys_init_ctrl),
      .cmd           (cmd_if),
      .abort         (abort),
      .rot_clk       (rot_clk),
      .rot_en        (rot_en),
      .rot_dir       (rot_dir),
      .busy          (busy),
      .done          (done),
      .done_aborted  (done_aborted),
      .steps_left    (steps_left),
      .angle_bcd     (angle_bcd)
   );

   always #10 clk50 = ~clk50;

   int          total = 0;
   int          passed = 0;
   int          fails = 0;
   logic        exp_dir;
   logic [15:0] hist[$];

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk50);
         #1;
      end
   endtask

   task automatic issue(input logic [13:0] s, input logic d);
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_steps = s;
      cmd_if.cmd_dir = d;
      exp_dir = d;
      tick(1);
      cmd_if.cmd_valid = 1'b0;
   endtask

   // Walks cycle by cycle until done, gathering pulse/enable statistics.
   task automatic run_move(input int budget, output int cyc,
                           output int pulses, output int hi,
                           output int en, output bit dir_bad);
      logic        pc;
      logic [15:0] pa;
      pc = 1'b0;
      pa = angle_bcd;
      hist.delete();
      cyc = 0;
      pulses = 0;
      hi = 0;
      en = 0;
      dir_bad = 1'b0;
      for (int i = 1; i <= budget; i++) begin
         if (angle_bcd !== pa) begin
            hist.push_back(angle_bcd);
            pa = angle_bcd;
         end
         if (done === 1'b1) begin
            cyc = i;
            break;
         end
         if (rot_clk && !pc) pulses++;
         if (rot_clk) hi++;
         if (rot_en) begin
            en++;
            if (rot_dir !== exp_dir) dir_bad = 1'b1;
         end
         pc = rot_clk;
         tick(1);
      end
      chk("move_ends", 64'(cyc > 0), 64'd1);
   endtask

   int cyc, pulses, hi, en;
   bit dir_bad, seen_done;

   initial begin
      sys_init_ctrl = 1'b1;
      abort = 1'b0;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_steps = '0;
      cmd_if.cmd_dir = 1'b0;
      exp_dir = 1'b0;
      tick(3);
      chk("rst_flags",
          {cmd_if.cmd_ready, rot_clk, rot_en, busy, done, done_aborted, rot_dir},
          7'b1000000);
      chk("rst_steps", steps_left, 0);
      chk("rst_angle", angle_bcd, 16'h0000);
      sys_init_ctrl = 1'b0;
      tick(1);

      // 3 steps clockwise
      issue(14'd3, 1'b0);
      chk("t1_first_rise", {rot_clk, rot_en, busy, cmd_if.cmd_ready}, 4'b1110);
      chk("t1_latched", steps_left, 3);
      run_move(200, cyc, pulses, hi, en, dir_bad);
      chk("t1_cycles", cyc, 32);
      chk("t1_pulses", pulses, 3);
      chk("t1_high", hi, 12);
      chk("t1_en", en, 31);
      chk("t1_hist_n", hist.size(), 3);
      if (hist.size() == 3)
         chk("t1_hist", {hist[0], hist[1], hist[2]}, 48'h0001_0002_0003);
      chk("t1_done", {done_aborted, rot_en, rot_clk}, 3'b000);
      chk("t1_left", steps_left, 0);
      tick(1);
      chk("t1_ready", {cmd_if.cmd_ready, done, busy}, 3'b100);

      // Down-count wrap from 0000
      sys_init_ctrl = 1'b1;
      tick(1);
      sys_init_ctrl = 1'b0;
      chk("t2_angle0", angle_bcd, 16'h0000);
      tick(1);
      issue(14'd2, 1'b1);
      run_move(200, cyc, pulses, hi, en, dir_bad);
      chk("t2_cycles", cyc, 22);
      chk("t2_dir", dir_bad, 0);
      chk("t2_hist_n", hist.size(), 2);
      if (hist.size() == 2)
         chk("t2_hist", {hist[0], hist[1]}, 32'h9999_9998);
      tick(1);

      // 1000 steps from 9998 lands on 0998
      issue(14'd1000, 1'b0);
      run_move(11000, cyc, pulses, hi, en, dir_bad);
      chk("t3_long_cycles", cyc, 10002);
      chk("t3_long_pulses", pulses, 1000);
      chk("t3_angle", angle_bcd, 16'h0998);
      tick(1);
      issue(14'd3, 1'b0);
      run_move(200, cyc, pulses, hi, en, dir_bad);
      chk("t3_hist_n", hist.size(), 3);
      if (hist.size() == 3)
         chk("t3_hist", {hist[0], hist[1], hist[2]}, 48'h0999_1000_1001);
      tick(1);

      // Abort at phase 2 of pulse 2
      issue(14'd5, 1'b0);
      tick(12);
      chk("t4_high_pre", rot_clk, 1'b1);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      chk("t4_fall", {rot_clk, rot_en}, 2'b01);
      chk("t4_left", steps_left, 3);
      chk("t4_angle", angle_bcd, 16'h1003);
      run_move(100, cyc, pulses, hi, en, dir_bad);
      chk("t4_settle", cyc, SC + 1);
      chk("t4_pulses", pulses, 0);
      chk("t4_aborted", done_aborted, 1'b1);
      chk("t4_final", {steps_left, angle_bcd}, {14'd3, 16'h1003});
      tick(1);
      chk("t4_ready", cmd_if.cmd_ready, 1'b1);

      // Zero-step move
      issue(14'd0, 1'b0);
      run_move(20, cyc, pulses, hi, en, dir_bad);
      chk("t5_cycles", cyc, 1);
      chk("t5_quiet", {pulses, en}, 64'd0);
      chk("t5_done", {cmd_if.cmd_ready, done_aborted}, 2'b00);
      tick(1);
      chk("t5_ready", {cmd_if.cmd_ready, done}, 2'b10);

      // Clamp, then reset mid-move
      issue(14'd12000, 1'b0);
      chk("t6_clamp", steps_left, 9999);
      tick(20);
      chk("t6_running", {busy, rot_clk, rot_en}, 3'b111);
      sys_init_ctrl = 1'b1;
      #2;
      chk("t6_async",
          {rot_clk, rot_en, busy, cmd_if.cmd_ready, angle_bcd},
          {4'b0001, 16'h0000});
      seen_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         if (done) seen_done = 1'b1;
      end
      sys_init_ctrl = 1'b0;
      tick(1);
      if (done) seen_done = 1'b1;
      chk("t6_no_done", seen_done, 1'b0);
      chk("t6_idle", {cmd_if.cmd_ready, busy, steps_left}, {2'b10, 14'd0});

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
